// File: rtl/fxp_mult_pipe.sv
// Pipelined multi-lane signed fixed-point multiplier with a loadable
// per-lane coefficient bank, valid/ready handshake with global stall,
// optional round-half-up and optional saturation with overflow flags.
module fxp_mult_pipe #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DECIMAL_BITS = 16,
  parameter int unsigned LANES        = 4,
  parameter int unsigned STAGES       = 2,
  parameter int unsigned ROUND        = 1,
  parameter int unsigned SAT          = 1,
  parameter logic signed [WIDTH-1:0] C_INIT = WIDTH'(65536),
  localparam int unsigned AW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     coef_wr_en,
  input  logic [AW-1:0]            coef_wr_addr,
  input  logic [WIDTH-1:0]         coef_wr_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   a_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   prod_out,
  output logic [LANES-1:0]         ovf_out
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] RND =
    (ROUND != 0) ? (PW'(1) << (DECIMAL_BITS - 1)) : '0;
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic                    stall;
  logic                    accept;
  logic [STAGES-1:0]       vld_q;
  logic signed [WIDTH-1:0] coef_q [LANES];
  logic signed [PW-1:0]    mul_c  [LANES];

  assign out_valid = vld_q[STAGES-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;

  // Round, range-check and optionally clamp one full product; returns {ovf, result}.
  function automatic logic [WIDTH:0] fmt(input logic signed [PW-1:0] p);
    logic signed [PW-1:0]    pr;
    logic signed [PW-1:0]    sh;
    logic signed [PW-1:0]    ext;
    logic signed [WIDTH-1:0] r;
    logic                    ovf;
    pr  = p + RND;
    sh  = pr >>> DECIMAL_BITS;
    r   = sh[WIDTH-1:0];
    ext = PW'(r);
    // Overflow when the shifted product is not the sign extension of its low slice.
    ovf = (sh != ext);
    if ((SAT != 0) && ovf) r = pr[PW-1] ? MINV : MAXV;
    return {ovf, r};
  endfunction

  // Coefficient bank; writes land regardless of stall, out-of-range addresses drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LANES; i++) coef_q[i] <= C_INIT;
    end else if (coef_wr_en) begin
      for (int unsigned i = 0; i < LANES; i++)
        if (32'(coef_wr_addr) == i) coef_q[i] <= coef_wr_data;
    end
  end

  // Full-width signed product per lane against the currently stored coefficient.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++)
      mul_c[i] = PW'($signed(a_in[i*WIDTH +: WIDTH])) * PW'(coef_q[i]);
  end

  // Stage valid bits; every stage holds while the output is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else if (!stall) begin
      vld_q[0] <= accept;
      for (int unsigned k = 1; k < STAGES; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  if (STAGES == 1) begin : g_one
    // Single stage: multiply, round and saturate straight into the output register.
    always_ff @(posedge clk) begin
      if (reset) begin
        prod_out <= '0;
        ovf_out  <= '0;
      end else if (accept) begin
        for (int unsigned i = 0; i < LANES; i++)
          {ovf_out[i], prod_out[i*WIDTH +: WIDTH]} <= fmt(mul_c[i]);
      end
    end
  end else begin : g_multi
    logic signed [PW-1:0] pr_q [STAGES-1][LANES];

    // Product pipeline: stage 1 captures the product, middle stages carry it.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned k = 0; k < STAGES - 1; k++)
          for (int unsigned i = 0; i < LANES; i++) pr_q[k][i] <= '0;
      end else if (!stall) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (accept) pr_q[0][i] <= mul_c[i];
          for (int unsigned k = 1; k < STAGES - 1; k++)
            if (vld_q[k-1]) pr_q[k][i] <= pr_q[k-1][i];
        end
      end
    end

    // Last stage: round/saturate into the held output register.
    always_ff @(posedge clk) begin
      if (reset) begin
        prod_out <= '0;
        ovf_out  <= '0;
      end else if (!stall && vld_q[STAGES-2]) begin
        for (int unsigned i = 0; i < LANES; i++)
          {ovf_out[i], prod_out[i*WIDTH +: WIDTH]} <= fmt(pr_q[STAGES-2][i]);
      end
    end
  end

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Scoreboard bench for fxp_mult_pipe: a default instance (round + saturate)
// and a raw instance (truncate + wrap) share all inputs and timing.
module tb_fxp_mult_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned L  = 4;
  localparam int unsigned ST = 2;
  localparam logic [31:0] ONE = 32'h00010000;
  localparam longint MAXV = 64'sh7FFFFFFF;
  localparam longint MINV = -64'sh80000000;

  typedef struct packed {
    logic [L*W-1:0] p;
    logic [L-1:0]   o;
    logic [L*W-1:0] pr;
    logic [L-1:0]   orr;
  } res_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           coef_wr_en = 1'b0;
  logic [1:0]     coef_wr_addr = '0;
  logic [W-1:0]   coef_wr_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready, in_ready_raw;
  logic [L*W-1:0] a_in = '0;
  logic           out_valid, out_valid_raw;
  logic           out_ready = 1'b1;
  logic [L*W-1:0] prod_out, prod_raw;
  logic [L-1:0]   ovf_out, ovf_raw;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int obs_cyc = 0;
  logic [W-1:0] coef_m [L];
  res_t exp_q[$];
  res_t obs_q[$];

  fxp_mult_pipe #(.WIDTH(W), .DECIMAL_BITS(16), .LANES(L), .STAGES(ST),
                  .ROUND(1), .SAT(1), .C_INIT(ONE)) u_dut (
    .clk(clk), .reset(reset), .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data), .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in),
    .out_valid(out_valid), .out_ready(out_ready), .prod_out(prod_out), .ovf_out(ovf_out));

  fxp_mult_pipe #(.WIDTH(W), .DECIMAL_BITS(16), .LANES(L), .STAGES(ST),
                  .ROUND(0), .SAT(0), .C_INIT(ONE)) u_raw (
    .clk(clk), .reset(reset), .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data), .in_valid(in_valid), .in_ready(in_ready_raw), .a_in(a_in),
    .out_valid(out_valid_raw), .out_ready(out_ready), .prod_out(prod_raw), .ovf_out(ovf_raw));

  always #5 clk = ~clk;

  // Reference arithmetic on 64-bit integers; returns {ovf, result}.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] c,
                                        input bit rnd, input bit sat);
    longint p, r;
    bit ov;
    logic [31:0] res;
    p = longint'($signed(a)) * longint'($signed(c));
    if (rnd) p = p + 64'sd32768;
    r = p >>> 16;
    ov = (r > MAXV) || (r < MINV);
    res = r[31:0];
    if (sat && ov) res = (p < 0) ? 32'h80000000 : 32'h7FFFFFFF;
    return {ov, res};
  endfunction

  function automatic res_t expect_res(input logic [L*W-1:0] a);
    res_t e;
    logic [32:0] m;
    e = '0;
    for (int i = 0; i < L; i++) begin
      m = model(a[i*W +: W], coef_m[i], 1'b1, 1'b1);
      e.p[i*W +: W] = m[31:0];
      e.o[i] = m[32];
      m = model(a[i*W +: W], coef_m[i], 1'b0, 1'b0);
      e.pr[i*W +: W] = m[31:0];
      e.orr[i] = m[32];
    end
    return e;
  endfunction

  // One clock of stimulus; records expected results at acceptance and observed at consumption.
  task automatic cycle(input bit rst, input bit iv, input logic [L*W-1:0] a, input bit ordy,
                       input bit wen, input logic [1:0] wa, input logic [31:0] wd,
                       output bit acc);
    @(negedge clk);
    reset = rst; in_valid = iv; a_in = a; out_ready = ordy;
    coef_wr_en = wen; coef_wr_addr = wa; coef_wr_data = wd;
    #1;
    acc = in_valid && in_ready && !rst;
    if (acc) begin
      exp_q.push_back(expect_res(a));
      acc_cyc = cyc;
    end
    if (out_valid && out_ready && !rst) begin
      obs_q.push_back({prod_out, ovf_out, prod_raw, ovf_raw});
      obs_cyc = cyc;
    end
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < L; i++) coef_m[i] = ONE;
    end else if (wen) begin
      coef_m[wa] = wd;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 2'd0, 32'd0, acc);
  endtask

  task automatic wr(input logic [1:0] lane, input logic [31:0] val);
    bit acc;
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, lane, val, acc);
  endtask

  task automatic send(input logic [L*W-1:0] a);
    bit acc;
    cycle(1'b0, 1'b1, a, 1'b1, 1'b0, 2'd0, 32'd0, acc);
  endtask

  task automatic test_reset();
    bit acc;
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 2'd0, 32'd0, acc);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 2'd0, 32'd0, acc);
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (prod_out !== '0) begin errs++; $display("FAIL reset_prod got %h want 0", prod_out); end
    checks++; if (ovf_out !== '0) begin errs++; $display("FAIL reset_ovf got %b want 0", ovf_out); end
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid_raw !== 1'b0) begin errs++; $display("FAIL reset_raw_valid got %b want 0", out_valid_raw); end
    checks++; if (in_ready_raw !== 1'b1) begin errs++; $display("FAIL reset_raw_ready got %b want 1", in_ready_raw); end
  endtask

  task automatic test_basic();
    res_t o, e;
    wr(2'd0, 32'h00018000);
    send({32'h00008000, 32'hFFFF0000, 32'h00020000, 32'h00020000});
    idle(4);
    checks++; if (obs_cyc - acc_cyc != ST) begin errs++; $display("FAIL basic_latency got %0d want %0d", obs_cyc - acc_cyc, ST); end
    checks++; if (obs_q.size() != 1) begin errs++; $display("FAIL basic_count got %0d want 1", obs_q.size()); end
    o = '0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errs++; $display("FAIL basic_result got %h want %h", o, e); end
    end
    checks++; if (o.p[31:0] !== 32'h00030000 || o.o[0] !== 1'b0) begin
      errs++; $display("FAIL basic_lane0 got %h/%b want 00030000/0", o.p[31:0], o.o[0]); end
  endtask

  task automatic test_round();
    res_t o, e;
    wr(2'd0, 32'h00008000);
    wr(2'd1, 32'h00008000);
    send({ONE, ONE, 32'hFFFFFFFF, 32'h00000001});
    idle(4);
    checks++; if (obs_q.size() != 1) begin errs++; $display("FAIL round_count got %0d want 1", obs_q.size()); end
    o = '0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errs++; $display("FAIL round_result got %h want %h", o, e); end
    end
    checks++; if (o.p[31:0] !== 32'h1) begin errs++; $display("FAIL round_up got %h want 00000001", o.p[31:0]); end
    checks++; if (o.pr[31:0] !== 32'h0) begin errs++; $display("FAIL round_trunc got %h want 00000000", o.pr[31:0]); end
    checks++; if (o.p[63:32] !== 32'h0) begin errs++; $display("FAIL round_neg got %h want 00000000", o.p[63:32]); end
  endtask

  task automatic test_saturate();
    res_t o, e;
    for (int i = 0; i < L; i++) wr(2'(i), 32'h00020000);
    send({32'h40000000, 32'h3FFFFFFF, 32'h80000000, 32'h7FFF0000});
    idle(4);
    checks++; if (obs_q.size() != 1) begin errs++; $display("FAIL sat_count got %0d want 1", obs_q.size()); end
    o = '0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errs++; $display("FAIL sat_result got %h want %h", o, e); end
    end
    checks++; if (o.p[31:0] !== 32'h7FFFFFFF || o.o[0] !== 1'b1) begin
      errs++; $display("FAIL sat_pos got %h/%b want 7fffffff/1", o.p[31:0], o.o[0]); end
    checks++; if (o.p[63:32] !== 32'h80000000 || o.o[1] !== 1'b1) begin
      errs++; $display("FAIL sat_neg got %h/%b want 80000000/1", o.p[63:32], o.o[1]); end
    checks++; if (o.pr[31:0] !== 32'hFFFE0000 || o.orr[0] !== 1'b1) begin
      errs++; $display("FAIL wrap_pos got %h/%b want fffe0000/1", o.pr[31:0], o.orr[0]); end
  endtask

  task automatic test_backpressure();
    res_t o, e;
    bit acc, have;
    int sent;
    logic [L*W+L-1:0] held;
    logic [L*W-1:0] a;
    sent = 0; have = 1'b0; held = '0;
    for (int i = 0; i < L; i++) wr(2'(i), ONE);
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < L; i++) a[i*W +: W] = 32'((sent + 1 + i) << 16);
      cycle(1'b0, sent < 8, a, !(k >= 3 && k < 8), 1'b0, 2'd0, 32'd0, acc);
      if (acc) sent++;
      if (out_valid && !out_ready) begin
        checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        if (have) begin
          checks++; if ({prod_out, ovf_out} !== held) begin
            errs++; $display("FAIL bp_stable got %h want %h", {prod_out, ovf_out}, held); end
        end
        held = {prod_out, ovf_out}; have = 1'b1;
      end else begin
        have = 1'b0;
      end
    end
    checks++; if (obs_q.size() != 8) begin errs++; $display("FAIL bp_count got %0d want 8", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errs++; $display("FAIL bp_result got %h want %h", o, e); end
    end
  endtask

  task automatic test_coef_race();
    res_t o, e;
    bit acc;
    cycle(1'b0, 1'b1, {L{ONE}}, 1'b1, 1'b1, 2'd2, 32'h00030000, acc);
    send({L{ONE}});
    idle(4);
    checks++; if (obs_q.size() != 2) begin
      errs++; $display("FAIL race_count got %0d want 2", obs_q.size());
    end else begin
      checks++; if (obs_q[0].p[95:64] !== ONE) begin
        errs++; $display("FAIL race_old got %h want 00010000", obs_q[0].p[95:64]); end
      checks++; if (obs_q[1].p[95:64] !== 32'h00030000) begin
        errs++; $display("FAIL race_new got %h want 00030000", obs_q[1].p[95:64]); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errs++; $display("FAIL race_result got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_midflight();
    res_t o, e;
    bit acc;
    for (int i = 0; i < L; i++) wr(2'(i), 32'h00030000);
    cycle(1'b0, 1'b1, {L{ONE}}, 1'b1, 1'b0, 2'd0, 32'd0, acc);
    cycle(1'b1, 1'b1, {L{32'h00020000}}, 1'b1, 1'b0, 2'd0, 32'd0, acc);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 2'd0, 32'd0, acc);
      checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
    end
    checks++; if (obs_q.size() != 0) begin errs++; $display("FAIL mid_flushed got %0d want 0", obs_q.size()); end
    send({L{ONE}});
    idle(4);
    checks++; if (obs_q.size() != 1) begin
      errs++; $display("FAIL mid_count got %0d want 1", obs_q.size());
    end else begin
      checks++; if (obs_q[0].p !== {L{ONE}}) begin
        errs++; $display("FAIL mid_coef_init got %h want %h", obs_q[0].p, {L{ONE}}); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin errs++; $display("FAIL mid_result got %h want %h", o, e); end
    end
  endtask

  initial begin
    for (int i = 0; i < L; i++) coef_m[i] = ONE;
    test_reset();
    test_basic();
    test_round();
    test_saturate();
    test_backpressure();
    test_coef_race();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
